// File: rtl/odt_uart_bridge.sv
// odt_uart_bridge: couples the DCJ11 console-ODT byte handshakes (rstb/rrdy for
// CPU->terminal, wrdy/wstb for terminal->CPU) on the shared ad bus to an 8N1 UART.
// Each direction is buffered by its own FIFO.
module odt_uart_bridge #(
    parameter int CLK_HZ     = 27_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16,
    parameter int AD_HOLD    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rstb,
    output logic       rrdy,
    input  logic       wstb,
    output logic       wrdy,
    inout  wire  [7:0] ad,
    output logic       uart_tx,
    input  logic       uart_rx,
    output logic       overrun,
    output logic       frame_err
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int PW  = AW + 1;
    localparam logic [15:0] DIV_M1  = 16'(DIV - 1);
    localparam logic [15:0] HALF_M1 = 16'(DIV / 2 - 1);
    localparam logic [7:0]  HOLD_M1 = 8'(AD_HOLD - 1);

    typedef enum logic       {T_IDLE, T_ACK} t_state_t;
    typedef enum logic [1:0] {W_IDLE, W_OFFER, W_HOLD, W_GAP} w_state_t;
    typedef enum logic       {TX_IDLE, TX_SHIFT} tx_state_t;
    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} r_state_t;

    t_state_t  t_state, t_next;
    w_state_t  w_state, w_next;
    tx_state_t tx_state, tx_next;
    r_state_t  r_state, r_next;

    logic rstb_m, rstb_s, wstb_m, wstb_s, uart_rx_m, uart_rx_s, uart_rx_d;

    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [AW:0]   tx_wp, tx_rp, rx_wp, rx_rp;
    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic          tx_push, tx_pop, rx_push, rx_pop;
    logic [7:0]    tx_head, rx_head;

    logic [15:0]   tx_cnt, rx_cnt;
    logic [8:0]    tx_sh;
    logic [3:0]    tx_left;
    logic          tx_bit_end;
    logic [7:0]    rx_sh;
    logic [2:0]    rx_bit;
    logic          rx_tick;
    logic [7:0]    ad_q;
    logic [7:0]    hold_cnt;
    logic          ad_drive;

    assign tx_full  = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
    assign tx_empty = (tx_wp == tx_rp);
    assign rx_full  = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
    assign rx_empty = (rx_wp == rx_rp);
    assign tx_head  = tx_mem[tx_rp[AW-1:0]];
    assign rx_head  = rx_mem[rx_rp[AW-1:0]];

    assign tx_bit_end = (tx_state == TX_SHIFT) && (tx_cnt == 16'd0);
    assign rx_tick    = (rx_cnt == 16'd0);

    assign tx_push = (t_state == T_IDLE) && rstb_s && !tx_full;
    assign tx_pop  = !tx_empty && ((tx_state == TX_IDLE) || (tx_bit_end && tx_left == 4'd0));
    assign rx_pop  = (w_state == W_OFFER) && wstb_s && !rstb_s;
    assign rx_push = (r_state == R_STOP) && rx_tick && uart_rx_s && (!rx_full || rx_pop);

    assign rrdy     = (t_state == T_IDLE);
    assign wrdy     = (w_state == W_OFFER);
    assign ad_drive = (w_state == W_OFFER) || (w_state == W_HOLD);
    assign ad       = ad_drive ? ad_q : 8'bz;

    // Two-flop synchronisers for the CPU strobes and the asynchronous serial input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rstb_m    <= 1'b0;
            rstb_s    <= 1'b0;
            wstb_m    <= 1'b0;
            wstb_s    <= 1'b0;
            uart_rx_m <= 1'b1;
            uart_rx_s <= 1'b1;
            uart_rx_d <= 1'b1;
        end else begin
            rstb_m    <= rstb;
            rstb_s    <= rstb_m;
            wstb_m    <= wstb;
            wstb_s    <= wstb_m;
            uart_rx_m <= uart_rx;
            uart_rx_s <= uart_rx_m;
            uart_rx_d <= uart_rx_s;
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp[AW-1:0]] <= ad;
        if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_sh;
    end

    // FIFO pointers; a same-cycle push and pop both advance, leaving the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wp <= '0;
            tx_rp <= '0;
            rx_wp <= '0;
            rx_rp <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + PW'(1);
            if (tx_pop)  tx_rp <= tx_rp + PW'(1);
            if (rx_push) rx_wp <= rx_wp + PW'(1);
            if (rx_pop)  rx_rp <= rx_rp + PW'(1);
        end
    end

    // State registers for all four handshake and UART machines.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_state  <= T_IDLE;
            w_state  <= W_IDLE;
            tx_state <= TX_IDLE;
            r_state  <= R_IDLE;
        end else begin
            t_state  <= t_next;
            w_state  <= w_next;
            tx_state <= tx_next;
            r_state  <= r_next;
        end
    end

    // Next-state logic; the offer path yields to a CPU strobe so ad is never fought over for long.
    always_comb begin
        t_next  = t_state;
        w_next  = w_state;
        tx_next = tx_state;
        r_next  = r_state;
        case (t_state)
            T_IDLE:  if (tx_push) t_next = T_ACK;
            default: if (!rstb_s) t_next = T_IDLE;
        endcase
        case (w_state)
            W_IDLE:  if (!rx_empty && !rstb_s && t_state == T_IDLE) w_next = W_OFFER;
            W_OFFER: if (rstb_s) w_next = W_IDLE;
                     else if (wstb_s) w_next = W_HOLD;
            W_HOLD:  if (hold_cnt == HOLD_M1) w_next = W_GAP;
            default: if (!wstb_s) w_next = W_IDLE;
        endcase
        case (tx_state)
            TX_IDLE: if (tx_pop) tx_next = TX_SHIFT;
            default: if (tx_bit_end && tx_left == 4'd0 && !tx_pop) tx_next = TX_IDLE;
        endcase
        case (r_state)
            R_IDLE:  if (uart_rx_d && !uart_rx_s) r_next = R_START;
            R_START: if (rx_tick) r_next = uart_rx_s ? R_IDLE : R_DATA;
            R_DATA:  if (rx_tick && rx_bit == 3'd7) r_next = R_STOP;
            R_STOP:  if (rx_tick) r_next = uart_rx_s ? R_IDLE : R_WAIT;
            default: if (uart_rx_s) r_next = R_IDLE;
        endcase
    end

    // Transmit shifter: start bit goes out on the pop edge, then d0..d7 and stop, DIV clocks each.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_cnt  <= 16'd0;
            tx_sh   <= 9'h1ff;
            tx_left <= 4'd0;
            uart_tx <= 1'b1;
        end else if (tx_pop) begin
            tx_sh   <= {1'b1, tx_head};
            tx_left <= 4'd9;
            tx_cnt  <= DIV_M1;
            uart_tx <= 1'b0;
        end else if (tx_bit_end) begin
            if (tx_left != 4'd0) begin
                uart_tx <= tx_sh[0];
                tx_sh   <= {1'b1, tx_sh[8:1]};
                tx_left <= tx_left - 4'd1;
                tx_cnt  <= DIV_M1;
            end else begin
                uart_tx <= 1'b1;
            end
        end else if (tx_cnt != 16'd0) begin
            tx_cnt <= tx_cnt - 16'd1;
        end
    end

    // Receive sampler: half a bit to the start-bit middle, then one bit period per sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_cnt    <= HALF_M1;
            rx_bit    <= 3'd0;
            rx_sh     <= 8'h00;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else if (r_state == R_IDLE) begin
            rx_cnt <= HALF_M1;
            rx_bit <= 3'd0;
        end else if (!rx_tick) begin
            rx_cnt <= rx_cnt - 16'd1;
        end else begin
            rx_cnt <= DIV_M1;
            if (r_state == R_DATA) begin
                rx_sh  <= {uart_rx_s, rx_sh[7:1]};
                rx_bit <= rx_bit + 3'd1;
            end
            if (r_state == R_STOP && uart_rx_s && rx_full && !rx_pop) overrun <= 1'b1;
            if (r_state == R_STOP && !uart_rx_s) frame_err <= 1'b1;
        end
    end

    // Offer datapath: ad_q tracks the RX head until offered, then freezes through the hold window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ad_q     <= 8'h00;
            hold_cnt <= 8'd0;
        end else begin
            if (w_state == W_IDLE) ad_q <= rx_head;
            hold_cnt <= (w_state == W_HOLD) ? hold_cnt + 8'd1 : 8'd0;
        end
    end
endmodule

// File: tb/tb_odt_uart_bridge.sv
// tb_odt_uart_bridge: directed checks of odt_uart_bridge. A fast instance (DIV=16)
// covers the handshakes, UART framing, errors and reset; a slow instance (DIV=200)
// keeps its transmitter busy so the TX FIFO can be filled.
module tb_odt_uart_bridge;
    localparam int DIV  = 16;
    localparam int DIVB = 200;

    logic       clk = 1'b0;
    logic       rst;
    logic       rstb, wstb, uart_rx;
    logic       rrdy, wrdy, uart_tx, overrun, frame_err;
    logic       ad_en;
    logic [7:0] ad_val;
    wire  [7:0] ad;

    logic       rstb_b;
    logic [7:0] ad_b_val;
    wire  [7:0] ad_b;
    logic       rrdy_b, wrdy_b, uart_tx_b, overrun_b, frame_err_b;

    int checks = 0;
    int passes = 0;

    assign ad   = ad_en ? ad_val : 8'bz;
    assign ad_b = ad_b_val;

    for (genvar i = 0; i < 8; i++) begin : g_pull
        pullup pu (ad[i]);
    end

    odt_uart_bridge #(.CLK_HZ(1600), .BAUD(100), .FIFO_DEPTH(16), .AD_HOLD(4)) u_dut (
        .clk(clk), .rst(rst), .rstb(rstb), .rrdy(rrdy), .wstb(wstb), .wrdy(wrdy),
        .ad(ad), .uart_tx(uart_tx), .uart_rx(uart_rx), .overrun(overrun),
        .frame_err(frame_err)
    );

    odt_uart_bridge #(.CLK_HZ(20000), .BAUD(100), .FIFO_DEPTH(16), .AD_HOLD(4)) u_blk (
        .clk(clk), .rst(rst), .rstb(rstb_b), .rrdy(rrdy_b), .wstb(1'b0), .wrdy(wrdy_b),
        .ad(ad_b), .uart_tx(uart_tx_b), .uart_rx(1'b1), .overrun(overrun_b),
        .frame_err(frame_err_b)
    );

    always #5 clk = ~clk;

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Serial frame into uart_rx, LSB first, with a chosen stop-bit level.
    task automatic applyStimulus(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        step(DIV);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            step(DIV);
        end
        uart_rx = stop;
        step(DIV);
        uart_rx = 1'b1;
        step(4);
    endtask

    task automatic cpuStrobe(input string tag, input logic [7:0] b);
        int n;
        ad_val = b;
        ad_en  = 1'b1;
        rstb   = 1'b1;
        n = 0;
        while (rrdy !== 1'b0 && n < 8) begin step(1); n++; end
        checkOutput(tag, 32'(rrdy), 0);
        rstb  = 1'b0;
        ad_en = 1'b0;
        n = 0;
        while (rrdy !== 1'b1 && n < 8) begin step(1); n++; end
    endtask

    task automatic cpuTake(output logic [7:0] v);
        int n;
        n = 0;
        while (wrdy !== 1'b1 && n < 20) begin step(1); n++; end
        v = ad;
        wstb = 1'b1;
        n = 0;
        while (wrdy !== 1'b0 && n < 8) begin step(1); n++; end
        step(6);
        wstb = 1'b0;
        step(5);
    endtask

    // Decode one frame from the slow instance; begins at any point inside its start bit.
    task automatic decodeB(output logic [7:0] v);
        int n;
        n = 0;
        while (uart_tx_b !== 1'b0 && n < 3 * DIVB) begin step(1); n++; end
        step(DIVB / 2);
        for (int i = 0; i < 8; i++) begin
            step(DIVB);
            v[i] = uart_tx_b;
        end
        step(DIVB);
    endtask

    initial begin
        int n;
        int zeros;
        logic [7:0] v;
        logic [9:0] frame41;

        rst = 1'b1; rstb = 1'b0; wstb = 1'b0; uart_rx = 1'b1;
        ad_en = 1'b0; ad_val = 8'h00; rstb_b = 1'b0; ad_b_val = 8'h00;
        step(3);
        checkOutput("reset_rrdy", 32'(rrdy), 1);
        checkOutput("reset_wrdy", 32'(wrdy), 0);
        checkOutput("reset_uart_tx", 32'(uart_tx), 1);
        checkOutput("reset_overrun", 32'(overrun), 0);
        checkOutput("reset_frame_err", 32'(frame_err), 0);
        checkOutput("reset_ad_released", 32'(ad), 32'hff);
        rst = 1'b0;
        step(2);

        // CPU strobe of 0x41 and the resulting serial frame.
        $display("[TB] test 1: CPU strobe 0x41");
        ad_val = 8'h41; ad_en = 1'b1; rstb = 1'b1;
        n = 0;
        while (rrdy !== 1'b0 && n < 4) begin step(1); n++; end
        checkOutput("t1_rrdy_ack", 32'(rrdy), 0);
        rstb = 1'b0; ad_en = 1'b0;
        n = 0;
        while (uart_tx !== 1'b0 && n < 10) begin step(1); n++; end
        step(DIV - 1);
        checkOutput("t1_start_full_width", 32'(uart_tx), 0);
        checkOutput("t1_rrdy_release", 32'(rrdy), 1);
        frame41 = 10'b1_0100_0001_0;
        for (int i = 1; i < 10; i++) begin
            step(i == 1 ? 1 : DIV);
            checkOutput($sformatf("t1_bit%0d", i), 32'(uart_tx), 32'(frame41[i]));
        end
        step(DIV);

        // Fill the slow instance: one byte goes to the shifter, sixteen fill the FIFO.
        $display("[TB] test 2: TX FIFO full");
        for (int i = 0; i < 17; i++) begin
            ad_b_val = 8'(i);
            rstb_b = 1'b1;
            n = 0;
            while (rrdy_b !== 1'b0 && n < 8) begin step(1); n++; end
            checkOutput($sformatf("t2_accept_%0d", i), 32'(rrdy_b), 0);
            rstb_b = 1'b0;
            n = 0;
            while (rrdy_b !== 1'b1 && n < 8) begin step(1); n++; end
        end
        ad_b_val = 8'd17;
        rstb_b = 1'b1;
        step(20);
        checkOutput("t2_full_reject", 32'(rrdy_b), 1);
        n = 0;
        while (rrdy_b !== 1'b0 && n < 12 * DIVB) begin step(1); n++; end
        checkOutput("t2_accept_after_pop", 32'(rrdy_b), 0);
        rstb_b = 1'b0;
        for (int i = 1; i < 18; i++) begin
            decodeB(v);
            checkOutput($sformatf("t2_order_%0d", i), 32'(v), 32'(i));
        end
        checkOutput("t2_no_offer", 32'(wrdy_b), 0);
        checkOutput("t2_no_overrun", 32'(overrun_b), 0);
        checkOutput("t2_no_frame_err", 32'(frame_err_b), 0);

        // Received byte offered to the CPU, then held for the AD_HOLD window.
        $display("[TB] test 3: RX 0x30 offer");
        applyStimulus(8'h30, 1'b1);
        n = 0;
        while (wrdy !== 1'b1 && n < 20) begin step(1); n++; end
        checkOutput("t3_wrdy", 32'(wrdy), 1);
        checkOutput("t3_ad_offer", 32'(ad), 32'h30);
        wstb = 1'b1;
        n = 0;
        while (wrdy !== 1'b0 && n < 6) begin step(1); n++; end
        checkOutput("t3_wrdy_fall", 32'(wrdy), 0);
        checkOutput("t3_hold_first", 32'(ad), 32'h30);
        step(3);
        checkOutput("t3_hold_last", 32'(ad), 32'h30);
        step(1);
        checkOutput("t3_release", 32'(ad), 32'hff);
        wstb = 1'b0;
        step(10);
        checkOutput("t3_no_reoffer", 32'(wrdy), 0);

        // CPU strobe during an offer: offer retracts, byte kept and re-offered.
        $display("[TB] test 4: contention");
        applyStimulus(8'h5a, 1'b1);
        n = 0;
        while (wrdy !== 1'b1 && n < 20) begin step(1); n++; end
        checkOutput("t4_offer", 32'(ad), 32'h5a);
        rstb = 1'b1;
        n = 0;
        while (ad !== 8'hff && n < 3) begin step(1); n++; end
        checkOutput("t4_release", 32'(ad), 32'hff);
        checkOutput("t4_wrdy", 32'(wrdy), 0);
        rstb = 1'b0;
        n = 0;
        while (wrdy !== 1'b1 && n < 10) begin step(1); n++; end
        checkOutput("t4_reoffer_wrdy", 32'(wrdy), 1);
        checkOutput("t4_reoffer_ad", 32'(ad), 32'h5a);
        cpuTake(v);
        checkOutput("t4_taken", 32'(v), 32'h5a);

        // Framing error, then overrun after sixteen unclaimed bytes.
        $display("[TB] test 5: errors");
        applyStimulus(8'h55, 1'b0);
        step(20);
        checkOutput("t5_frame_err", 32'(frame_err), 1);
        checkOutput("t5_no_push", 32'(wrdy), 0);
        checkOutput("t5_no_overrun_yet", 32'(overrun), 0);
        for (int i = 0; i < 17; i++) applyStimulus(8'(8'h10 + i), 1'b1);
        checkOutput("t5_overrun", 32'(overrun), 1);
        for (int i = 0; i < 16; i++) begin
            cpuTake(v);
            checkOutput($sformatf("t5_held_%0d", i), 32'(v), 32'(8'h10 + i));
        end
        step(10);
        checkOutput("t5_drained", 32'(wrdy), 0);

        // Reset in the middle of a transmitted frame with an RX byte pending.
        $display("[TB] test 6: reset mid-frame");
        cpuStrobe("t6_strobe_a", 8'h00);
        cpuStrobe("t6_strobe_b", 8'h00);
        applyStimulus(8'h3c, 1'b1);
        n = 0;
        while (wrdy !== 1'b1 && n < 20) begin step(1); n++; end
        checkOutput("t6_rx_pending", 32'(wrdy), 1);
        checkOutput("t6_mid_frame", 32'(uart_tx), 0);
        rst = 1'b1;
        #1;
        checkOutput("t6_uart_tx_now", 32'(uart_tx), 1);
        checkOutput("t6_wrdy_now", 32'(wrdy), 0);
        checkOutput("t6_ad_now", 32'(ad), 32'hff);
        checkOutput("t6_sticky_clear", 32'({overrun, frame_err}), 0);
        step(2);
        rst = 1'b0;
        zeros = 0;
        for (int i = 0; i < 3 * DIV; i++) begin
            step(1);
            if (uart_tx === 1'b0) zeros++;
        end
        checkOutput("t6_no_glitch_frame", 32'(zeros), 0);
        checkOutput("t6_rx_empty", 32'(wrdy), 0);
        checkOutput("t6_rrdy", 32'(rrdy), 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
